inv_sbox_engine: RTL

INV_SBOX_ENGINE -- requirements
Module: inv_sbox_engine

---
 rtl/inv_sbox_engine.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/inv_sbox_engine.sv
// Iterative AES InvSubBytes engine.
// Each clock, BYTES_PER_CYCLE bytes of a 128-bit working state are replaced by
// their inverse S-box value. One lookup lane is instantiated per byte.
// Outputs are registered one cycle after the FSM state, so done appears N+1
// edges after the start edge and busy is high for N cycles.
// Optional build macro: INV_SBOX_SELFCHECK_EN adds a forward S-box per lane.
// Each lane checks that fwd(inv(x)) == x and reports a mismatch on a sticky
// checkErr flag.

module inv_sbox_lane (
    input  logic [7:0] din,
    output logic [7:0] dout
`ifdef INV_SBOX_SELFCHECK_EN
    ,
    output logic       err
`endif
);
    // Entry 0 sits in the top byte; byte offset of entry x is 8*(255-x) = {~x,3'b0}
    localparam logic [2047:0] INV_TAB = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign dout = INV_TAB[{~din, 3'b000} +: 8];

`ifdef INV_SBOX_SELFCHECK_EN
    localparam logic [2047:0] FWD_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign err = (FWD_TAB[{~dout, 3'b000} +: 8] != din);
`endif
endmodule

module inv_sbox_engine #(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] stateIn,
    output logic [127:0] stateOut,
    output logic         busy,
    output logic         done,
    output logic         checkErr
);
    localparam int N  = 16 / BYTES_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                              state;
    logic [CW-1:0]                       cnt;
    logic [15:0][7:0]                    work;      // work[15] is byte 0
    logic [3:0]                          base;      // first byte index of current group
    logic                                last_grp;
    logic [BYTES_PER_CYCLE-1:0][7:0]     lane_in;
    logic [BYTES_PER_CYCLE-1:0][7:0]     lane_out;
    logic                                accept;

    assign base     = 4'(int'(cnt) * BYTES_PER_CYCLE);
    assign last_grp = (cnt == CW'(N - 1));
    assign accept   = ((state == IDLE) || (state == DONE)) && start;

`ifdef INV_SBOX_SELFCHECK_EN
    logic [BYTES_PER_CYCLE-1:0]          lane_err;
`endif

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
        assign lane_in[g] = work[4'd15 - (base + 4'(g))];
        inv_sbox_lane u_lane (
            .din  (lane_in[g]),
            .dout (lane_out[g])
`ifdef INV_SBOX_SELFCHECK_EN
            ,
            .err  (lane_err[g])
`endif
        );
    end

    // Control FSM, working register and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            work     <= '0;
            stateOut <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (state == RUN);
            done <= (state == DONE);
            if (state == DONE)
                stateOut <= work;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        work  <= stateIn;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    for (int l = 0; l < BYTES_PER_CYCLE; l++)
                        work[4'd15 - (base + 4'(l))] <= lane_out[l];
                    cnt <= cnt + 1'b1;
                    if (last_grp)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INV_SBOX_SELFCHECK_EN
    // Sticky round-trip error: cleared by an accepted start, set by any lane mismatch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            checkErr <= 1'b0;
        else if (accept)
            checkErr <= 1'b0;
        else if ((state == RUN) && (|lane_err))
            checkErr <= 1'b1;
    end
`else
    assign checkErr = 1'b0;
`endif
endmodule
